// File: rtl/counter_load_ctrl_pkg.sv
// Shared definitions for the serial load-command front end of the loadable counter.
// Holds the FSM state encoding and the frame geometry derived from the data width.
package counter_load_ctrl_pkg;

  typedef enum logic [1:0] {
    LCTL_IDLE  = 2'd0,
    LCTL_SHIFT = 2'd1,
    LCTL_LOAD  = 2'd2
  } lctl_state_t;

  // One command bit followed by data_w data bits.
  function automatic int unsigned frame_bits(input int unsigned data_w);
    return data_w + 1;
  endfunction

  // The command bit is the first one shifted in, so it lands above the data.
  function automatic int unsigned cmd_bit(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/counter_load_ctrl_sync_edge.sv
// N-stage synchroniser for an asynchronous pin with registered edge pulses.
// Ports:
//   in_clk, in_rst_n : clock, asynchronous active-low reset
//   in_d             : asynchronous input
//   out_q            : synchronised level
//   out_rise         : one-cycle pulse after out_q goes 0->1
//   out_fall         : one-cycle pulse after out_q goes 1->0
module counter_load_ctrl_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic in_d,
  output logic out_q,
  output logic out_rise,
  output logic out_fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchroniser chain, then one edge-detect register feeding registered pulses.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      sync_r   <= {STAGES{RST_VAL}};
      prev_r   <= RST_VAL;
      out_rise <= 1'b0;
      out_fall <= 1'b0;
    end else begin
      sync_r   <= {sync_r[STAGES-2:0], in_d};
      prev_r   <= sync_r[STAGES-1];
      out_rise <= sync_r[STAGES-1] & ~prev_r;
      out_fall <= ~sync_r[STAGES-1] & prev_r;
    end
  end

  assign out_q = sync_r[STAGES-1];

endmodule

// File: rtl/counter_load_ctrl.sv
// Serial load-command receiver in front of the loadable counter.
// Synchronises cs_n/sclk/sdata, deserialises a {cmd, data} frame MSB first and
// drives the counter's load value, a LOAD_HOLD-cycle load strobe and the
// write-enable level.
// Ports:
//   in_clk, in_rst_n       : clock, asynchronous active-low reset
//   in_cs_n, in_sclk       : frame select (active low) and serial clock, async
//   in_sdata               : serial data, sampled on sclk rising edge
//   out_load_value         : last accepted data word
//   out_load_now           : load strobe, LOAD_HOLD cycles
//   out_write_now          : write/drive enable, 0 during LOAD
//   out_frame_err          : sticky, last frame malformed
//   out_busy               : high in SHIFT or LOAD
module counter_load_ctrl
  import counter_load_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned LOAD_HOLD   = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_cs_n,
  input  logic              in_sclk,
  input  logic              in_sdata,
  output logic [DATA_W-1:0] out_load_value,
  output logic              out_load_now,
  output logic              out_write_now,
  output logic              out_frame_err,
  output logic              out_busy
);

  localparam int unsigned FRAME_BITS = frame_bits(DATA_W);
  localparam int unsigned CMD_BIT    = cmd_bit(DATA_W);
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 2);
  localparam int unsigned HOLD_W     = $clog2(LOAD_HOLD + 1);

  logic cs_q, cs_rise, cs_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic sdata_q;
  logic unused_sclk;

  logic [SYNC_STAGES-1:0] sdata_sync_r;
  lctl_state_t            state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [FRAME_BITS-1:0]  shift_r;
  logic                   write_cmd;

  counter_load_ctrl_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs_sync (
    .in_clk  (in_clk),
    .in_rst_n(in_rst_n),
    .in_d    (in_cs_n),
    .out_q   (cs_q),
    .out_rise(cs_rise),
    .out_fall(cs_fall)
  );

  counter_load_ctrl_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sclk_sync (
    .in_clk  (in_clk),
    .in_rst_n(in_rst_n),
    .in_d    (in_sclk),
    .out_q   (sclk_q),
    .out_rise(sclk_rise),
    .out_fall(sclk_fall)
  );

  // Only the sclk rising edge is used.
  assign unused_sclk = sclk_q ^ sclk_fall;

  // sdata needs only a level; it is stable long before the delayed sclk pulse.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) sdata_sync_r <= '0;
    else           sdata_sync_r <= {sdata_sync_r[SYNC_STAGES-2:0], in_sdata};
  end

  assign sdata_q = sdata_sync_r[SYNC_STAGES-1];

  // Frame FSM with registered outputs.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state          <= LCTL_IDLE;
      bit_cnt        <= '0;
      hold_cnt       <= '0;
      shift_r        <= '0;
      write_cmd      <= 1'b0;
      out_load_value <= '0;
      out_load_now   <= 1'b0;
      out_write_now  <= 1'b0;
      out_frame_err  <= 1'b0;
      out_busy       <= 1'b0;
    end else begin
      case (state)
        LCTL_IDLE: begin
          if (cs_fall) begin
            state    <= LCTL_SHIFT;
            bit_cnt  <= '0;
            out_busy <= 1'b1;
          end
        end
        LCTL_SHIFT: begin
          if (cs_rise) begin
            if (bit_cnt == CNT_W'(FRAME_BITS)) begin
              out_load_value <= shift_r[DATA_W-1:0];
              write_cmd      <= shift_r[CMD_BIT];
              out_frame_err  <= 1'b0;
              out_load_now   <= 1'b1;
              out_write_now  <= 1'b0;
              hold_cnt       <= HOLD_W'(1);
              state          <= LCTL_LOAD;
            end else begin
              out_frame_err <= 1'b1;
              out_busy      <= 1'b0;
              state         <= LCTL_IDLE;
            end
          end else if (sclk_rise) begin
            shift_r <= {shift_r[FRAME_BITS-2:0], sdata_q};
            // Saturate one past a full frame so overruns stay distinguishable.
            if (bit_cnt != CNT_W'(FRAME_BITS + 1)) bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        LCTL_LOAD: begin
          if (hold_cnt == HOLD_W'(LOAD_HOLD)) begin
            out_load_now  <= 1'b0;
            out_write_now <= write_cmd;
            hold_cnt      <= '0;
            // A frame that began during LOAD has lost bits; collect the rest
            // so its closing edge is reported as malformed.
            if (!cs_q) begin
              state   <= LCTL_SHIFT;
              bit_cnt <= '0;
            end else begin
              state    <= LCTL_IDLE;
              out_busy <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state        <= LCTL_IDLE;
          out_load_now <= 1'b0;
          out_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/counter_load_ctrl.md
Name: counter_load_ctrl

Overview:
Upstream stage of the 8-bit loadable counter. Receives a serial load command from external pins (cs_n / sclk / sdata), asynchronous to in_clk. Synchronises the command and deserialises it. Drives the counter's load value, its load strobe (held at least 2 cycles, as the counter requires) and its write-enable level. Sits between the TT input/bidir pins and the counter.

Parameters:
DATA_W, 8, width of load value and counter
LOAD_HOLD, 2, in_clk cycles out_load_now is held high; legal range 2..15
SYNC_STAGES, 2, flip-flop depth of input synchronisers; legal range 2..3

Ports:
in_clk  input  1  system clock
in_rst_n  input  1  asynchronous active-low reset
in_cs_n  input  1  frame select, active low, async to in_clk
in_sclk  input  1  serial clock, async; data sampled on its rising edge
in_sdata  input  1  serial data, MSB first
out_load_value  output  DATA_W  last accepted data word; to counter load value
out_load_now  output  1  load strobe to counter
out_write_now  output  1  write/drive-enable level to counter
out_frame_err  output  1  sticky: last frame was malformed
out_busy  output  1  high in SHIFT or LOAD

Behaviour:
- Reset: in_rst_n is asynchronous, active-low; clock is in_clk.
- Reset values: all outputs 0, synchronisers 0, cs_n synchroniser 1, state IDLE, bit count 0.
- in_cs_n, in_sclk and in_sdata each pass through SYNC_STAGES flops, then one edge-detect register. in_sclk frequency must be ≤ in_clk/4.
- Frame layout, MSB first: 1 command bit, then DATA_W data bits, giving FRAME_BITS = DATA_W+1.
- Command bit: 1 = load then write (drive), 0 = load only.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE:
  - Synchronised cs_n falling edge -> SHIFT, with bit count cleared.
  - sclk edges while cs_n is high are ignored.
- SHIFT:
  - On each synchronised sclk rising edge, shift the synchronised sdata into the shift register LSB and increment the bit count.
  - The bit count saturates at FRAME_BITS+1 (overrun marker).
  - On synchronised cs_n rising edge:
    - If count == FRAME_BITS: latch out_load_value <= data bits and write_cmd <= command bit, clear out_frame_err, go to LOAD.
    - Otherwise: set out_frame_err, leave out_load_value and out_write_now unchanged, go to IDLE.
- LOAD:
  - out_load_now = 1 for exactly LOAD_HOLD cycles.
  - First assertion is the cycle after the cs_n rising edge is detected. Worst-case latency from the pin edge is SYNC_STAGES+2 cycles.
  - out_write_now is forced to 0 throughout LOAD, so the counter sees load only.
  - After LOAD_HOLD cycles -> IDLE.
- out_write_now = write_cmd whenever state != LOAD. It holds until the next accepted frame and is registered.
- out_load_now and out_busy are registered. No combinational path from input to output.
- cs_n falling edge during LOAD: ignored, and sclk edges are not shifted. The frame in progress completes with a short count, so it sets out_frame_err. LOAD always completes its LOAD_HOLD cycles.
- cs_n glitch, i.e. a rising edge while in IDLE: no effect.
- Reset mid-frame or mid-LOAD: immediate return to reset values. The partial frame is discarded; out_load_now deasserts asynchronously.
- All counter arithmetic is unsigned. The load-hold counter is clog2(LOAD_HOLD+1) bits wide.

Decomposition:
- Shared package/header holds:
  - state encodings LCTL_IDLE=2'd0, LCTL_SHIFT=2'd1, LCTL_LOAD=2'd2
  - FRAME_BITS derivation
  - command bit position constant CMD_BIT = DATA_W
- One sub-module is natural: sync_edge. It is a parameterised N-stage synchroniser with registered rise/fall pulse outputs, instantiated for cs_n and sclk; sdata uses only its synchronised output.

Test Plan:
- Reset: hold in_rst_n low with pins toggling -> all outputs 0, out_busy 0; release -> state IDLE, no strobe.
- Valid frame 1_0xA5, sclk = in_clk/8:
  - out_load_value=0xA5 and out_load_now high for exactly 2 cycles, starting ≤4 cycles after cs_n rises.
  - out_write_now is 0 during the strobe and 1 afterwards.
  - Counter model then shows count 0xA5, 0xA6, and so on.
- Frame 0_0x3C after the previous one -> out_load_value=0x3C, out_write_now falls to 0 and stays 0; out_frame_err stays 0.
- Short frame (5 bits) and long frame (12 bits) -> no out_load_now, out_load_value holds 0x3C, out_frame_err=1. A following valid 0x01 frame clears out_frame_err.
- cs_n falls during LOAD (LOAD_HOLD=4 build) -> strobe is still 4 cycles; the overlapping frame is flagged out_frame_err=1.
- in_rst_n asserted on the 2nd out_load_now cycle -> out_load_now 0 immediately, out_load_value 0. The next valid frame after release loads normally.
